req_ack_scheduler: RTL and testbench
====================================

// Module: req_ack_scheduler
// PURPOSE
//  Shares one fixed-latency req/ack responder between N_CLIENTS requesters.
//  The responder takes 1-cycle req pulses spaced >= MIN_GAP cycles apart and answers ack ACK_LATENCY cycles later.
//  - Round-robin arbitration between clients; issues protocol-legal req pulses.
//  - Checks ack timing and returns per-client done/err pulses.
//  - Sits between client logic and the responder (the DUT req/ack side).
// PARAMETERS
//  N_CLIENTS    4   number of requesters, >= 2
//  MIN_GAP      8   min cycles from one req pulse to the next (req at T -> next req >= T+MIN_GAP)
//  ACK_LATENCY  4   expected cycles from req to ack, < MIN_GAP
//  ACK_TIMEOUT  12  last cycle after req at which ack is accepted, > ACK_LATENCY
// PORTS
//  clk            in   1          single clock, all logic on posedge
//  rst            in   1          asynchronous, active-high reset
//  client_req     in   N_CLIENTS  level request per client, held until its done/err
//  client_done    out  N_CLIENTS  1-cycle pulse: transaction for client i finished
//  client_err     out  N_CLIENTS  1-cycle pulse with done: ack mistimed or timed out
//  req            out  1          registered 1-cycle req pulse to responder
//  ack            in   1          responder acknowledge
//  busy           out  1          transaction in flight (ISSUE or WAIT)
//  spurious_ack   out  1          sticky: ack seen while no transaction in flight
//  req_count      out  32         total req pulses issued (REQ_ACK_SCHED_STATS_EN)
//  ack_count      out  32         total acks accepted (REQ_ACK_SCHED_STATS_EN)
// BEHAVIOUR
//  Reset values: all outputs 0; rr pointer = N_CLIENTS-1 (client 0 wins first); gap_ok = 1.
//  Reset is asynchronous; assertion mid-transaction aborts it with no done/err.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE:
//   - IDLE: if |client_req && gap_ok, latch winner id and go to ISSUE.
//     Winner is the first requesting index after the rr pointer, wrapping N_CLIENTS-1 -> 0.
//   - ISSUE: req=1 for exactly this cycle (cycle T); gap counter and wait counter start; go to WAIT.
//   - WAIT: cnt = cycles since T.
//     - ack at cnt in 1..ACK_TIMEOUT: done[id] pulses next cycle; err[id] also pulses if cnt != ACK_LATENCY.
//     - No ack by cnt==ACK_TIMEOUT: done[id] and err[id] pulse next cycle.
//     - Either case: rr pointer = id; go to IDLE.
//  Latency, nominal case: client_req seen at C -> req at C+1 -> ack at C+5 -> done at C+6.
//  Spacing: gap_ok goes high at cycle T+MIN_GAP-1 evaluation, so the next req is never before T+MIN_GAP.
//   - Next req is also never before the ack/timeout of the previous one.
//  Back-to-back clients with nominal acks: req pulses exactly MIN_GAP cycles apart.
//  Client drops client_req before being granted: ignored.
//  Client drops client_req after grant: transaction completes; done still pulses.
//  ack in IDLE, or a second ack in the same transaction: sets spurious_ack (sticky until rst); otherwise ignored.
//  ack in the same cycle as req (cnt 0): treated as spurious.
//  Counters wrap at 2^32.
// CONFIGURATION
//  REQ_ACK_SCHED_STATS_EN defined:
//   - req_count increments on each req pulse.
//   - ack_count increments on each accepted ack (including mistimed ones).
//  Undefined: both ports are tied to 0 and no counter flops exist.
// TESTING (N_CLIENTS=4, MIN_GAP=8, ACK_LATENCY=4, ACK_TIMEOUT=12)
//  1. client_req=0001 from C, ack at req+4 -> req at C+1, client_done=0001 at C+6, client_err=0.
//  2. client_req=1111 held, nominal acks -> grants 0,1,2,3,0; req pulses exactly 8 cycles apart.
//  3. client_req=0100, ack never -> done=err=0100 at req+13; next req >= req+13.
//  4. client_req=0010, ack at req+2 -> done=err=0010 at req+3; next req still at >= req+8.
//  5. ack pulsed while idle -> spurious_ack=1 and held through later traffic until rst.
//  6. rst at req+2 -> req=0 immediately, no done/err; after release with client_req=1010, client 1 wins first.
//     With REQ_ACK_SCHED_STATS_EN, after test 2 (5 txns): req_count=5, ack_count=5.

Source files
------------

// File: rtl/req_ack_scheduler_if.sv
// Client/responder bundle for req_ack_scheduler.
// The master modport is the scheduler side and the slave modport is the environment side.
interface req_ack_scheduler_if #(
  parameter int N_CLIENTS = 4
);
  logic [N_CLIENTS-1:0] client_req;
  logic [N_CLIENTS-1:0] client_done;
  logic [N_CLIENTS-1:0] client_err;
  logic                 req;
  logic                 ack;
  logic                 busy;
  logic                 spurious_ack;
  logic [31:0]          req_count;
  logic [31:0]          ack_count;

  modport master (
    input  client_req, ack,
    output client_done, client_err, req, busy, spurious_ack, req_count, ack_count
  );

  modport slave (
    output client_req, ack,
    input  client_done, client_err, req, busy, spurious_ack, req_count, ack_count
  );
endinterface

// File: rtl/req_ack_scheduler.sv
// Round-robin sharing of one fixed-latency req/ack responder between N_CLIENTS requesters.
// Define REQ_ACK_SCHED_STATS_EN to build the req_count/ack_count statistics counters.
module req_ack_scheduler #(
  parameter int N_CLIENTS   = 4,
  parameter int MIN_GAP     = 8,
  parameter int ACK_LATENCY = 4,
  parameter int ACK_TIMEOUT = 12
) (
  input  logic                clk,
  input  logic                rst,
  req_ack_scheduler_if.master bus
);
  localparam int ID_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;

  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(ACK_LATENCY);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(ACK_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP - 1);
  localparam logic [ID_W-1:0]  RR_INIT = ID_W'(N_CLIENTS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 req_q, req_d;
  logic [N_CLIENTS-1:0] done_q, done_d;
  logic [N_CLIENTS-1:0] err_q, err_d;
  logic                 spur_q, spur_d;

  logic                 gap_ok;
  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      cand;

  // gap_q saturates at MIN_GAP-1, which is the first cycle a new grant may be evaluated.
  assign gap_ok = (gap_q == GAP_MAX);

  // Scan starts just after the last served client, so it has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      cand = ID_W'((int'(rr_q) + k) % N_CLIENTS);
      if (!win_found && bus.client_req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_ok ? gap_q : gap_q + 1'b1;
    done_d  = '0;
    err_d   = '0;
    spur_d  = spur_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ack) spur_d = 1'b1;
        if (win_found && gap_ok) begin
          state_d = S_ISSUE;
          id_d    = win_id;
        end
      end
      S_ISSUE: begin
        if (bus.ack) spur_d = 1'b1;
        gap_d   = GAP_W'(1);
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.ack || (cnt_q == CNT_TMO)) begin
          done_d[id_q] = 1'b1;
          err_d[id_q]  = !bus.ack || (cnt_q != CNT_LAT);
          rr_d         = id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_ISSUE);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      rr_q    <= RR_INIT;
      cnt_q   <= '0;
      gap_q   <= GAP_MAX;
      req_q   <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      spur_q  <= spur_d;
    end
  end

  assign bus.req          = req_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.client_done  = done_q;
  assign bus.client_err   = err_q;
  assign bus.spurious_ack = spur_q;

`ifdef REQ_ACK_SCHED_STATS_EN
  logic        ack_acc;
  logic [31:0] req_count_q;
  logic [31:0] ack_count_q;

  // Any ack while waiting is accepted, mistimed or not.
  assign ack_acc = (state_q == S_WAIT) && bus.ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_count_q <= '0;
      ack_count_q <= '0;
    end else begin
      if (req_d)   req_count_q <= req_count_q + 32'd1;
      if (ack_acc) ack_count_q <= ack_count_q + 32'd1;
    end
  end

  assign bus.req_count = req_count_q;
  assign bus.ack_count = ack_count_q;
`else
  assign bus.req_count = '0;
  assign bus.ack_count = '0;
`endif
endmodule

// File: tb/tb_req_ack_scheduler.sv
// Self-checking bench for req_ack_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a time-based reference model.
module tb_req_ack_scheduler;
  localparam int N           = 4;
  localparam int IW          = $clog2(N);
  localparam int MIN_GAP     = 8;
  localparam int ACK_LATENCY = 4;
  localparam int ACK_TIMEOUT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_ack_scheduler_if #(.N_CLIENTS(N)) bus ();

  req_ack_scheduler #(
    .N_CLIENTS  (N),
    .MIN_GAP    (MIN_GAP),
    .ACK_LATENCY(ACK_LATENCY),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N-1:0] creq;
    int           ack_lat;   // cycles from req to ack, -1 = never
    int           done_rel;  // expected done cycle relative to req
    logic         err;
  } vec_t;

  typedef struct {
    int           cyc;
    logic [N-1:0] done;
    logic [N-1:0] err;
  } done_rec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a transaction is described by its req time and owner.
  logic          m_active;
  int            m_treq;
  logic [IW-1:0] m_owner;
  logic [IW-1:0] m_ptr;
  logic          m_spur;
  logic [N-1:0]  m_done;
  logic [N-1:0]  m_err;
  int            m_reqs;
  int            m_acks;

  int        resp_lat;
  int        ack_at;
  int        req_log[$];
  done_rec_t done_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_treq   = -1000;
    m_owner  = '0;
    m_ptr    = IW'(N - 1);
    m_spur   = 1'b0;
    m_done   = '0;
    m_err    = '0;
    m_reqs   = 0;
    m_acks   = 0;
  endtask

  // Evaluate cycle `cyc` with its inputs; leaves the expected outputs for cycle cyc+1.
  task automatic model_eval(input logic [N-1:0] creq, input logic a);
    logic [N-1:0]  nd;
    logic [N-1:0]  ne;
    logic [IW-1:0] idx;
    logic          found;
    int            age;
    nd    = '0;
    ne    = '0;
    found = 1'b0;
    age   = cyc - m_treq;
    if (m_active) begin
      if (a && age == 0) begin
        m_spur = 1'b1;
      end else if (a || age == ACK_TIMEOUT) begin
        nd[m_owner] = 1'b1;
        ne[m_owner] = !a || (age != ACK_LATENCY);
        if (a) m_acks++;
        m_active = 1'b0;
        m_ptr    = m_owner;
      end
    end else begin
      if (a) m_spur = 1'b1;
      if (creq != '0 && age >= MIN_GAP - 1) begin
        for (int k = 1; k <= N; k++) begin
          idx = IW'((int'(m_ptr) + k) % N);
          if (!found && creq[idx]) begin
            found   = 1'b1;
            m_owner = idx;
          end
        end
        m_active = 1'b1;
        m_treq   = cyc + 1;
        m_reqs++;
      end
    end
    m_done = nd;
    m_err  = ne;
  endtask

  // Called at posedge+1 with this cycle's inputs driven; returns at posedge+1 of the next cycle.
  task automatic step();
    @(negedge clk);
    check("req", 64'(bus.req), 64'(m_active && (cyc == m_treq)));
    check("busy", 64'(bus.busy), 64'(m_active));
    check("done", 64'(bus.client_done), 64'(m_done));
    check("err", 64'(bus.client_err), 64'(m_err));
    check("spurious", 64'(bus.spurious_ack), 64'(m_spur));
`ifdef REQ_ACK_SCHED_STATS_EN
    check("req_count", 64'(bus.req_count), 64'(m_reqs));
    check("ack_count", 64'(bus.ack_count), 64'(m_acks));
`else
    check("req_count", 64'(bus.req_count), 64'd0);
    check("ack_count", 64'(bus.ack_count), 64'd0);
`endif
    if (bus.req === 1'b1) begin
      req_log.push_back(cyc);
      if (resp_lat >= 1) ack_at = cyc + resp_lat;
    end
    if (bus.client_done !== '0) done_log.push_back('{cyc, bus.client_done, bus.client_err});
    model_eval(bus.client_req, bus.ack);
    @(posedge clk);
    #1;
    cyc++;
    bus.client_req = bus.client_req & ~m_done;
    bus.ack        = (cyc == ack_at);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    req_log.delete();
    done_log.delete();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.client_req = '0;
    bus.ack        = 1'b0;
    #1;
    check("rst_req", 64'(bus.req), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.client_done), 64'd0);
    check("rst_err", 64'(bus.client_err), 64'd0);
    check("rst_spurious", 64'(bus.spurious_ack), 64'd0);
    check("rst_req_count", 64'(bus.req_count), 64'd0);
    check("rst_ack_count", 64'(bus.ack_count), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cyc   += 2;
    ack_at = -1;
    model_reset();
    clear_logs();
  endtask

  vec_t         vecs[7];
  int           c0;
  logic [N-1:0] cr;

  initial begin
    bus.client_req = '0;
    bus.ack        = 1'b0;
    resp_lat       = ACK_LATENCY;
    ack_at         = -1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    vecs[0] = '{4'b0001, 4, 5, 1'b0};
    vecs[1] = '{4'b0100, -1, 13, 1'b1};
    vecs[2] = '{4'b0010, 2, 3, 1'b1};
    vecs[3] = '{4'b1000, 1, 2, 1'b1};
    vecs[4] = '{4'b0001, 12, 13, 1'b1};
    vecs[5] = '{4'b0010, 11, 12, 1'b1};
    vecs[6] = '{4'b0100, 4, 5, 1'b0};

    // Single-client transactions: latency, ack window edges and timeout.
    for (int r = 0; r < 7; r++) begin
      idle(12);
      clear_logs();
      c0             = cyc;
      bus.client_req = vecs[r].creq;
      resp_lat       = vecs[r].ack_lat;
      for (int i = 0; i < 40 && done_log.size() == 0; i++) step();
      check("vec_done_seen", 64'(done_log.size()), 64'd1);
      if (req_log.size() > 0 && done_log.size() > 0) begin
        check("vec_req_cycle", 64'(req_log[0] - c0), 64'd1);
        check("vec_done_rel", 64'(done_log[0].cyc - req_log[0]), 64'(vecs[r].done_rel));
        check("vec_done_vec", 64'(done_log[0].done), 64'(vecs[r].creq));
        check("vec_err_vec", 64'(done_log[0].err), vecs[r].err ? 64'(vecs[r].creq) : 64'd0);
      end
    end

    // All clients requesting with nominal acks: rotation 0,1,2,3,0 at MIN_GAP spacing.
    idle(4);
    do_reset();
    resp_lat = ACK_LATENCY;
    for (int i = 0; i < 80 && req_log.size() < 5; i++) begin
      bus.client_req = '1;
      step();
    end
    bus.client_req = '0;
    idle(12);
    check("rr_req_total", 64'(req_log.size()), 64'd5);
    check("rr_done_total", 64'(done_log.size()), 64'd5);
    if (req_log.size() == 5 && done_log.size() == 5) begin
      for (int i = 1; i < 5; i++) check("rr_spacing", 64'(req_log[i] - req_log[i-1]), 64'(MIN_GAP));
      for (int i = 0; i < 5; i++) begin
        check("rr_grant", 64'(done_log[i].done), 64'(1 << (i % N)));
        check("rr_err", 64'(done_log[i].err), 64'd0);
      end
    end
`ifdef REQ_ACK_SCHED_STATS_EN
    check("stats_req_count", 64'(bus.req_count), 64'd5);
    check("stats_ack_count", 64'(bus.ack_count), 64'd5);
`endif

    // Timeout: done+err at req+13, next grant evaluated in that cycle.
    clear_logs();
    resp_lat       = -1;
    bus.client_req = 4'b0100;
    for (int i = 0; i < 60 && done_log.size() < 2; i++) begin
      step();
      if (req_log.size() == 1) begin
        resp_lat       = ACK_LATENCY;
        bus.client_req = bus.client_req | 4'b0001;
      end
    end
    check("tmo_done_total", 64'(done_log.size()), 64'd2);
    if (req_log.size() == 2 && done_log.size() == 2) begin
      check("tmo_done_rel", 64'(done_log[0].cyc - req_log[0]), 64'd13);
      check("tmo_done_vec", 64'(done_log[0].done), 64'b0100);
      check("tmo_err_vec", 64'(done_log[0].err), 64'b0100);
      check("tmo_next_req", 64'(req_log[1] - req_log[0]), 64'd14);
      check("tmo_next_done", 64'(done_log[1].done), 64'b0001);
    end

    // Early ack: err at req+3, but the next req still waits for MIN_GAP.
    idle(12);
    clear_logs();
    resp_lat       = 2;
    bus.client_req = 4'b0010;
    for (int i = 0; i < 40 && done_log.size() < 2; i++) begin
      step();
      if (req_log.size() == 1) begin
        resp_lat       = ACK_LATENCY;
        bus.client_req = bus.client_req | 4'b0001;
      end
    end
    check("early_done_total", 64'(done_log.size()), 64'd2);
    if (req_log.size() == 2 && done_log.size() == 2) begin
      check("early_done_rel", 64'(done_log[0].cyc - req_log[0]), 64'd3);
      check("early_err_vec", 64'(done_log[0].err), 64'b0010);
      check("early_next_req", 64'(req_log[1] - req_log[0]), 64'(MIN_GAP));
    end

    // Ack in the req cycle is spurious; the transaction still completes on time.
    idle(4);
    do_reset();
    resp_lat       = ACK_LATENCY;
    bus.client_req = 4'b0001;
    step();
    bus.ack = 1'b1;
    step();
    check("cnt0_ack_spurious", 64'(bus.spurious_ack), 64'd1);
    idle(10);
    check("cnt0_done_total", 64'(done_log.size()), 64'd1);
    if (done_log.size() == 1) check("cnt0_err", 64'(done_log[0].err), 64'd0);

    // Ack while idle sets the sticky flag, which survives later traffic.
    do_reset();
    idle(3);
    bus.ack = 1'b1;
    step();
    check("idle_ack_spurious", 64'(bus.spurious_ack), 64'd1);
    bus.client_req = 4'b1000;
    idle(15);
    check("spurious_sticky", 64'(bus.spurious_ack), 64'd1);

    // Reset mid-transaction: aborts silently, rr pointer restarts so client 1 wins.
    do_reset();
    resp_lat       = ACK_LATENCY;
    bus.client_req = 4'b1000;
    for (int i = 0; i < 10 && req_log.size() == 0; i++) step();
    check("abort_req_seen", 64'(req_log.size()), 64'd1);
    step();
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    do_reset();
    bus.client_req = 4'b1010;
    for (int i = 0; i < 30 && done_log.size() == 0; i++) step();
    check("abort_first_grant", 64'(done_log.size() > 0 ? done_log[0].done : '0), 64'b0010);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cr = bus.client_req;
      for (int c = 0; c < N; c++) begin
        if (!cr[c] && $urandom_range(0, 5) == 0) cr[c] = 1'b1;
        else if (cr[c] && $urandom_range(0, 39) == 0) cr[c] = 1'b0;
      end
      bus.client_req = cr;
      case ($urandom_range(0, 9))
        0:       resp_lat = -1;
        1, 2:    resp_lat = int'($urandom_range(1, 14));
        default: resp_lat = ACK_LATENCY;
      endcase
      if ($urandom_range(0, 39) == 0) bus.ack = 1'b1;
      step();
    end
    bus.client_req = '0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
